csr_access_unit: RTL

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/csr_access_unit.sv
// Sequences CSRRW/RS/RC, trap entry and MRET against an external CSR file.
// Latency accept->resp_valid: CSR op 3 (illegal CSR 2), TRAP 6, MRET 2, reserved op 1.
// Backpressure: response held until resp_ready; req_ready only in IDLE.
module csr_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_csr,
    input  logic [63:0] req_src,
    input  logic [63:0] req_pc,
    input  logic [63:0] req_cause,
    input  logic [63:0] req_tval,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_redirect,
    output logic [63:0] resp_pc,
    output logic        resp_illegal,
    output logic [11:0] csr_ra,
    input  logic [63:0] csr_rd,
    output logic        csr_wvalid,
    output logic [11:0] csr_wa,
    output logic [63:0] csr_wd,
    output logic        csr_is_mret
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD      = 4'd1;
    localparam logic [3:0] S_WR      = 4'd2;
    localparam logic [3:0] S_T_EPC   = 4'd3;
    localparam logic [3:0] S_T_CAUSE = 4'd4;
    localparam logic [3:0] S_T_TVAL  = 4'd5;
    localparam logic [3:0] S_T_STAT  = 4'd6;
    localparam logic [3:0] S_T_VEC   = 4'd7;
    localparam logic [3:0] S_M_RET   = 4'd8;
    localparam logic [3:0] S_RESP    = 4'd9;

    localparam logic [2:0] OP_RW   = 3'd0;
    localparam logic [2:0] OP_RS   = 3'd1;
    localparam logic [2:0] OP_RC   = 3'd2;
    localparam logic [2:0] OP_TRAP = 3'd3;
    localparam logic [2:0] OP_MRET = 3'd4;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;

    logic [3:0]  state, state_d;
    logic        live;
    logic [2:0]  op_q;
    logic [11:0] csr_q;
    logic [63:0] src_q, pc_q, cause_q, tval_q;
    logic [63:0] old_q, tgt_q;
    logic        illegal_q, redirect_q;
    logic [63:0] new_val, stat_new;
    logic        accept, csr_ok;

    function automatic logic csr_supported(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC,
            A_MCAUSE, A_MTVAL, A_MIP, A_MCYCLE: csr_supported = 1'b1;
            default:                            csr_supported = 1'b0;
        endcase
    endfunction

    // live holds req_ready low until the first edge after reset release
    assign req_ready = live && (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign csr_ok    = csr_supported(csr_q);

    assign resp_valid    = (state == S_RESP);
    assign resp_rdata    = resp_valid ? old_q : 64'd0;
    assign resp_pc       = resp_valid ? tgt_q : 64'd0;
    assign resp_redirect = resp_valid && redirect_q;
    assign resp_illegal  = resp_valid && illegal_q;

    always_comb begin
        state_d     = state;
        csr_ra      = 12'd0;
        csr_wvalid  = 1'b0;
        csr_wa      = 12'd0;
        csr_wd      = 64'd0;
        csr_is_mret = 1'b0;

        case (op_q)
            OP_RS:   new_val = old_q | src_q;
            OP_RC:   new_val = old_q & ~src_q;
            default: new_val = src_q;
        endcase

        // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode
        stat_new        = csr_rd;
        stat_new[7]     = csr_rd[3];
        stat_new[3]     = 1'b0;
        stat_new[12:11] = 2'b11;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_RW, OP_RS, OP_RC: state_d = S_RD;
                        OP_TRAP:             state_d = S_T_EPC;
                        OP_MRET:             state_d = S_M_RET;
                        default:             state_d = S_RESP;
                    endcase
                end
            end
            S_RD: begin
                csr_ra  = csr_q;
                state_d = csr_ok ? S_WR : S_RESP;
            end
            S_WR: begin
                csr_wvalid = (op_q == OP_RW) || (src_q != 64'd0);
                csr_wa     = csr_q;
                csr_wd     = new_val;
                state_d    = S_RESP;
            end
            S_T_EPC: begin
                csr_wvalid = 1'b1;
                csr_wa     = A_MEPC;
                csr_wd     = pc_q;
                state_d    = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_wvalid = 1'b1;
                csr_wa     = A_MCAUSE;
                csr_wd     = cause_q;
                state_d    = S_T_TVAL;
            end
            S_T_TVAL: begin
                csr_wvalid = 1'b1;
                csr_wa     = A_MTVAL;
                csr_wd     = tval_q;
                state_d    = S_T_STAT;
            end
            S_T_STAT: begin
                csr_ra     = A_MSTATUS;
                csr_wvalid = 1'b1;
                csr_wa     = A_MSTATUS;
                csr_wd     = stat_new;
                state_d    = S_T_VEC;
            end
            S_T_VEC: begin
                csr_ra  = A_MTVEC;
                state_d = S_RESP;
            end
            S_M_RET: begin
                csr_ra      = A_MEPC;
                csr_is_mret = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            live       <= 1'b0;
            op_q       <= 3'd0;
            csr_q      <= 12'd0;
            src_q      <= 64'd0;
            pc_q       <= 64'd0;
            cause_q    <= 64'd0;
            tval_q     <= 64'd0;
            old_q      <= 64'd0;
            tgt_q      <= 64'd0;
            illegal_q  <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            live  <= 1'b1;
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= req_op;
                        csr_q      <= req_csr;
                        src_q      <= req_src;
                        pc_q       <= req_pc;
                        cause_q    <= req_cause;
                        tval_q     <= req_tval;
                        old_q      <= 64'd0;
                        tgt_q      <= 64'd0;
                        redirect_q <= 1'b0;
                        illegal_q  <= (req_op > OP_MRET);
                    end
                end
                S_RD: begin
                    if (csr_ok) old_q     <= csr_rd;
                    else        illegal_q <= 1'b1;
                end
                S_T_VEC: begin
                    tgt_q      <= {csr_rd[63:2], 2'b00};
                    redirect_q <= 1'b1;
                end
                S_M_RET: begin
                    tgt_q      <= csr_rd;
                    redirect_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
